// File: rtl/register_file_sb.sv
// Parametrised integer register file with two async read ports, one write port and a busy scoreboard.
// Define RF_BYPASS_EN to forward same-cycle writeback data and busy-clear onto the read ports.
module register_file_sb #(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int AW       = $clog2(NREGS),
    parameter bit ZERO_REG = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [AW-1:0]   A1,
    input  logic [AW-1:0]   A2,
    output logic [XLEN-1:0] RD1,
    output logic [XLEN-1:0] RD2,
    input  logic [AW-1:0]   A3,
    input  logic [XLEN-1:0] WD3,
    input  logic            WE3,
    input  logic            ISS,
    input  logic [AW-1:0]   AI,
    output logic            BUSY1,
    output logic            BUSY2,
    output logic [AW:0]     NBUSY
);

    localparam logic [AW:0] NREGS_W = (AW+1)'(NREGS);

    logic [XLEN-1:0] regs [NREGS];
    logic [NREGS-1:0] busy;
    logic [AW:0]      nbusy_q;

    logic set_v;
    logic clr_v;
    logic inc;
    logic dec;

    // A register is addressable when in range and not the hardwired zero.
    function automatic logic addr_valid(input logic [AW-1:0] a);
        return ({1'b0, a} < NREGS_W) && !(ZERO_REG && (a == '0));
    endfunction

    assign set_v = ISS && addr_valid(AI);
    assign clr_v = WE3 && addr_valid(A3);
    assign inc   = set_v && !busy[AI];
    // A clear on the register being set this cycle is overridden, so it never decrements.
    assign dec   = clr_v && busy[A3] && !(set_v && (AI == A3));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
            busy    <= '0;
            nbusy_q <= '0;
        end else begin
            if (clr_v) begin
                regs[A3] <= WD3;
                busy[A3] <= 1'b0;
            end
            if (set_v) begin
                busy[AI] <= 1'b1;
            end
            nbusy_q <= nbusy_q + (AW+1)'(inc) - (AW+1)'(dec);
        end
    end

    assign NBUSY = nbusy_q;

    always_comb begin
        RD1   = '0;
        RD2   = '0;
        BUSY1 = 1'b0;
        BUSY2 = 1'b0;
        if (rst_n && addr_valid(A1)) begin
            RD1   = regs[A1];
            BUSY1 = busy[A1];
        end
        if (rst_n && addr_valid(A2)) begin
            RD2   = regs[A2];
            BUSY2 = busy[A2];
        end
`ifdef RF_BYPASS_EN
        // Writeback in flight this cycle: forward its data and drop busy unless re-issued.
        if (rst_n && clr_v && (A3 == A1)) begin
            RD1   = WD3;
            BUSY1 = set_v && (AI == A1);
        end
        if (rst_n && clr_v && (A3 == A2)) begin
            RD2   = WD3;
            BUSY2 = set_v && (AI == A2);
        end
`endif
    end

endmodule

// File: tb/tb_register_file_sb.sv
// Directed and randomized bench for register_file_sb (NREGS=24) against an array-based reference model.
// Expectations follow RF_BYPASS_EN when the bench is built with that macro.
module tb_register_file_sb;

    localparam int  XL = 32;
    localparam int  NR = 24;
    localparam int  AWL = 5;
    localparam bit  ZR = 1'b1;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [AWL-1:0] a1, a2, a3, ai;
    logic [XL-1:0]  wd3;
    logic           we3, iss;
    logic [XL-1:0]  rd1, rd2;
    logic           busy1, busy2;
    logic [AWL:0]   nbusy;

    int checks = 0;
    int errors = 0;

    logic [XL-1:0] m_mem [NR];
    bit            m_bsy [NR];

    register_file_sb #(.XLEN(XL), .NREGS(NR), .AW(AWL), .ZERO_REG(ZR)) dut (
        .clk(clk), .rst_n(rst_n),
        .A1(a1), .A2(a2), .RD1(rd1), .RD2(rd2),
        .A3(a3), .WD3(wd3), .WE3(we3),
        .ISS(iss), .AI(ai),
        .BUSY1(busy1), .BUSY2(busy2), .NBUSY(nbusy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [XL-1:0] obs, input logic [XL-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit m_valid(input logic [AWL-1:0] a);
        return (int'(a) < NR) && !(ZR && a == 0);
    endfunction

    function automatic logic [XL-1:0] m_rd(input logic [AWL-1:0] a);
        if (!m_valid(a)) return '0;
`ifdef RF_BYPASS_EN
        if (we3 && m_valid(a3) && a3 == a) return wd3;
`endif
        return m_mem[a];
    endfunction

    function automatic logic m_busy(input logic [AWL-1:0] a);
        if (!m_valid(a)) return 1'b0;
`ifdef RF_BYPASS_EN
        if (we3 && m_valid(a3) && a3 == a) return iss && (ai == a);
`endif
        return m_bsy[a];
    endfunction

    function automatic int m_count();
        int n = 0;
        for (int i = 0; i < NR; i++) n += int'(m_bsy[i]);
        return n;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < NR; i++) begin
            m_mem[i] = '0;
            m_bsy[i] = 1'b0;
        end
    endtask

    // Clock edge in the model: write then clear then set, so a same-register set wins.
    task automatic m_edge();
        if (we3 && m_valid(a3)) begin
            m_mem[a3] = wd3;
            m_bsy[a3] = 1'b0;
        end
        if (iss && m_valid(ai)) m_bsy[ai] = 1'b1;
    endtask

    task automatic tick();
        @(negedge clk);
        chk("rd1", rd1, m_rd(a1));
        chk("rd2", rd2, m_rd(a2));
        chk("busy1", 32'(busy1), 32'(m_busy(a1)));
        chk("busy2", 32'(busy2), 32'(m_busy(a2)));
        @(posedge clk);
        m_edge();
        #1;
        chk("nbusy", 32'(nbusy), 32'(m_count()));
    endtask

    initial begin
        rst_n = 1'b0;
        a1 = '0; a2 = '0; a3 = '0; ai = '0; wd3 = '0; we3 = 1'b0; iss = 1'b0;
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_rd1", rd1, 32'h0);
        chk("reset_nbusy", 32'(nbusy), 32'h0);
        rst_n = 1'b1;

        // Async reset mid-cycle
        a3 = 5; wd3 = 32'hDEADBEEF; we3 = 1'b1;
        tick();
        we3 = 1'b0; iss = 1'b1; ai = 5;
        tick();
        iss = 1'b0; a1 = 5;
        #1;
        chk("pre_rst_rd1", rd1, 32'hDEADBEEF);
        chk("pre_rst_busy1", 32'(busy1), 32'h1);
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_rd1", rd1, 32'h0);
        chk("async_rst_busy1", 32'(busy1), 32'h0);
        chk("async_rst_nbusy", 32'(nbusy), 32'h0);
        m_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Hardwired zero register
        a3 = 0; wd3 = 32'hFFFFFFFF; we3 = 1'b1;
        tick();
        we3 = 1'b0; iss = 1'b1; ai = 0;
        tick();
        iss = 1'b0; a1 = 0;
        #1;
        chk("zero_rd1", rd1, 32'h0);
        chk("zero_busy1", 32'(busy1), 32'h0);
        chk("zero_nbusy", 32'(nbusy), 32'h0);

        // Same-cycle read of the register being written
        a1 = 7; a3 = 7; wd3 = 32'h12345678; we3 = 1'b1;
        #2;
`ifdef RF_BYPASS_EN
        chk("bypass_rd1", rd1, 32'h12345678);
`else
        chk("nobypass_rd1", rd1, 32'h0);
`endif
        tick();
        we3 = 1'b0;
        #1;
        chk("after_write_rd1", rd1, 32'h12345678);

        // Scoreboard set/clear
        iss = 1'b1; ai = 3;
        tick();
        chk("sb_nbusy1", 32'(nbusy), 32'd1);
        ai = 4;
        tick();
        chk("sb_nbusy2", 32'(nbusy), 32'd2);
        iss = 1'b0; we3 = 1'b1; a3 = 3; wd3 = 32'h33;
        tick();
        chk("sb_nbusy3", 32'(nbusy), 32'd1);
        we3 = 1'b0; a1 = 4; a2 = 3;
        #1;
        chk("sb_busy1", 32'(busy1), 32'h1);
        chk("sb_busy2", 32'(busy2), 32'h0);

        // Set and clear on the same register: set wins
        iss = 1'b1; ai = 9; we3 = 1'b1; a3 = 9; wd3 = 32'hA5;
        tick();
        chk("coll_nbusy", 32'(nbusy), 32'd2);
        we3 = 1'b0;
        tick();
        chk("coll_reissue_nbusy", 32'(nbusy), 32'd2);
        iss = 1'b0; a1 = 9;
        #1;
        chk("coll_busy1", 32'(busy1), 32'h1);
        chk("coll_rd1", rd1, 32'hA5);

        // Out-of-range write and issue
        we3 = 1'b1; a3 = 30; wd3 = 32'h1; iss = 1'b1; ai = 30;
        tick();
        chk("oor_nbusy", 32'(nbusy), 32'd2);
        we3 = 1'b0; iss = 1'b0; a1 = 30;
        #1;
        chk("oor_rd1", rd1, 32'h0);
        chk("oor_busy1", 32'(busy1), 32'h0);

        // Randomized traffic, addresses cover the unmapped range too
        for (int n = 0; n < 400; n++) begin
            a1  = AWL'($urandom_range(0, 31));
            a2  = AWL'($urandom_range(0, 31));
            a3  = AWL'($urandom_range(0, 31));
            ai  = ($urandom_range(0, 3) == 0) ? a3 : AWL'($urandom_range(0, 31));
            wd3 = $urandom;
            we3 = 1'($urandom_range(0, 1));
            iss = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) a1 = a3;
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/register_file_sb.md
Name: register_file_sb

Overview:
- Parametrised successor to the fermi32 integer register file.
- Two combinational read ports, one synchronous write port, optional hardwired-zero register.
- Adds an asynchronous active-low reset and a per-register busy scoreboard, so decode can detect RAW hazards against in-flight writebacks.
- Sits between decode (reads, issue) and writeback (write, busy clear).

Parameters:
- XLEN, 32, data width in bits.
- NREGS, 32, number of architectural registers (2 to 2**AW).
- AW, $clog2(NREGS), address width.
- ZERO_REG, 1, when 1 register 0 reads as 0, ignores writes and never becomes busy.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- A1  input  AW  read port 1 address.
- A2  input  AW  read port 2 address.
- RD1  output  XLEN  read data 1.
- RD2  output  XLEN  read data 2.
- A3  input  AW  write address.
- WD3  input  XLEN  write data.
- WE3  input  1  write enable; also clears busy[A3].
- ISS  input  1  issue strobe; sets busy[AI].
- AI  input  AW  issue destination register.
- BUSY1  output  1  busy flag for A1.
- BUSY2  output  1  busy flag for A2.
- NBUSY  output  AW+1  count of busy registers.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n. Assertion immediately clears all registers, all busy bits and NBUSY to 0. While rst_n is low, RD1 = RD2 = 0 and BUSY1 = BUSY2 = 0. Deassertion takes effect at the first following clk rising edge. Reset mid-operation discards any pending write or issue in that cycle.
- Reads: combinational, zero latency. RDn = reg[An]. The value written at an edge is visible on RDn after that edge.
- Read of register 0 with ZERO_REG=1: returns 0.
- Out-of-range read (An >= NREGS): returns 0, BUSYn = 0.
- Write: at clk rising edge, if WE3, then reg[A3] <= WD3.
  - Ignored when A3 is out of range.
  - Ignored when A3 == 0 and ZERO_REG=1.
- Scoreboard, at clk rising edge:
  - set = ISS and AI is valid.
  - clr = WE3 and A3 is valid.
  - "Valid" means in range, and not 0 when ZERO_REG=1.
  - busy[AI] <= 1 on set; busy[A3] <= 0 on clr.
  - Same register set and clr in one cycle: set wins, register stays or becomes busy.
  - Set on an already-busy register: no change.
  - Clr on a non-busy register: no change.
- NBUSY: registered; always equals the popcount of busy bits after each edge.
  - +1 when a non-busy register becomes busy.
  - -1 when a busy register becomes non-busy.
  - Both in one cycle on different registers: net 0.
  - Cannot overflow, since the maximum is NREGS.
- BUSYn: busy[An], subject to the optional bypass below.
- Writes to different registers from the one issued: independent.

Optional Feature:
- RF_BYPASS_EN defined: write-through forwarding.
  - If WE3 and A3 == An and A3 is valid, then RDn = WD3 in the same cycle.
  - In the same case, BUSYn = 0 unless ISS and AI == An in that cycle.
  - This gives zero-cycle writeback-to-decode forwarding.
- RF_BYPASS_EN undefined:
  - RDn and BUSYn reflect only registered state.
  - A same-cycle read of the register being written returns the old value.
  - The new value appears one cycle later.

Test Plan:
- Reset: write reg5=0xDEADBEEF, ISS AI=5, then pulse rst_n low mid-cycle. Required: RD1(A1=5)=0 and NBUSY=0 immediately, without waiting for a clock edge.
- Register 0 (ZERO_REG=1): WE3 A3=0 WD3=0xFFFFFFFF, then ISS AI=0. Required: RD1(A1=0)=0, BUSY1=0, NBUSY=0.
- Write/read and bypass: WE3 A3=7 WD3=0x12345678 while A1=7. Required: RD1=old value 0 without RF_BYPASS_EN; RD1=0x12345678 the same cycle with RF_BYPASS_EN; 0x12345678 after the edge in both builds.
- Scoreboard set/clear: ISS AI=3, then ISS AI=4, then WE3 A3=3. Required: NBUSY goes 1, 2, 1; BUSY1(A1=4)=1 and BUSY2(A2=3)=0 at the end.
- Collision: reg9 not busy, ISS AI=9 together with WE3 A3=9 WD3=0xA5. Required: busy[9]=1, NBUSY +1, reg9=0xA5. Then ISS AI=9 again: NBUSY unchanged.
- Out-of-range (NREGS=24, AW=5): WE3 A3=30 WD3=0x1 and ISS AI=30. Required: RD1(A1=30)=0, NBUSY unchanged.
